// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 keystream checker: FSM states,
// default accepted-character window and the byte screening function.
package rc4_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH_I,
      S_FETCH_J,
      S_SWAP_I,
      S_SWAP_J,
      S_FETCH_K,
      S_EMIT,
      S_DONE
   } state_t;

   localparam int CHAR_LO_DEF    = 97;
   localparam int CHAR_HI_DEF    = 122;
   localparam int CHAR_EXTRA_DEF = 32;

   function automatic logic char_ok(input logic [7:0] b, input logic [7:0] lo,
                                    input logic [7:0] hi, input logic [7:0] extra);
      return ((b >= lo) && (b <= hi)) || (b == extra);
   endfunction

endpackage

// File: rtl/rc4_prga_checker_edge_detector.sv
// Rising-edge detector for a level request; rise is combinational from the
// current level and the previous-cycle sample.
module edge_detector (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic rise
);

   logic sig_q;

   always_ff @(posedge clk) begin
      if (reset) sig_q <= 1'b0;
      else       sig_q <= sig;
   end

   assign rise = sig & ~sig_q;

endmodule

// File: rtl/rc4_prga_checker.sv
// RC4 PRGA: decrypts msg_len ciphertext bytes with a KSA-initialised S-box,
// writes plaintext and screens each byte. Define RC4_FULL_SCAN_EN to scan the
// whole message instead of aborting on the first rejected byte.
module rc4_prga_checker
   import rc4_pkg::*;
#(
   parameter int SBOX_AW    = 8,
   parameter int MSG_AW     = 5,
   parameter int CHAR_LO    = CHAR_LO_DEF,
   parameter int CHAR_HI    = CHAR_HI_DEF,
   parameter int CHAR_EXTRA = CHAR_EXTRA_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [MSG_AW:0]    msg_len,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [MSG_AW-1:0]  fail_idx,
   output logic [SBOX_AW-1:0] s_addr,
   output logic [7:0]         s_wdata,
   output logic               s_wren,
   input  logic [7:0]         s_rdata,
   output logic [MSG_AW-1:0]  ct_addr,
   input  logic [7:0]         ct_rdata,
   output logic [MSG_AW-1:0]  pt_addr,
   output logic [7:0]         pt_wdata,
   output logic               pt_wren
);

   localparam int LW = MSG_AW + 1;
   localparam logic [MSG_AW:0] MAX_LEN = LW'(1) << MSG_AW;

   state_t             state;
   logic [SBOX_AW-1:0] i, j, j_new;
   logic [MSG_AW-1:0]  k;
   logic [MSG_AW:0]    len;
   logic [7:0]         si, sj, pt_byte;
   logic               start_rise, byte_ok, last;
`ifdef RC4_FULL_SCAN_EN
   logic               bad;
`endif

   edge_detector u_start_edge (
      .clk   (clk),
      .reset (reset),
      .sig   (start),
      .rise  (start_rise)
   );

   assign j_new   = j + SBOX_AW'(s_rdata);
   assign pt_byte = s_rdata ^ ct_rdata;
   assign byte_ok = char_ok(pt_byte, 8'(CHAR_LO), 8'(CHAR_HI), 8'(CHAR_EXTRA));
   assign last    = (LW'(k) == len - LW'(1));

   // Memory buses follow the state directly: FETCH_J must forward the read
   // data into the j address in the same cycle it arrives.
   always_comb begin
      s_addr   = '0;
      s_wdata  = '0;
      s_wren   = 1'b0;
      ct_addr  = '0;
      pt_addr  = '0;
      pt_wdata = '0;
      pt_wren  = 1'b0;
      case (state)
         S_FETCH_I: s_addr = i + 1'b1;
         S_FETCH_J: s_addr = j_new;
         S_SWAP_I: begin
            s_addr  = i;
            s_wdata = s_rdata;
            s_wren  = 1'b1;
         end
         S_SWAP_J: begin
            s_addr  = j;
            s_wdata = si;
            s_wren  = 1'b1;
         end
         S_FETCH_K: begin
            s_addr  = SBOX_AW'(si) + SBOX_AW'(sj);
            ct_addr = k;
         end
         S_EMIT: begin
            pt_addr  = k;
            pt_wdata = pt_byte;
            pt_wren  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         i        <= '0;
         j        <= '0;
         k        <= '0;
         len      <= '0;
         si       <= '0;
         sj       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         fail_idx <= '0;
`ifdef RC4_FULL_SCAN_EN
         bad      <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: if (start_rise) begin
               len      <= (msg_len > MAX_LEN) ? MAX_LEN : msg_len;
               i        <= '0;
               j        <= '0;
               k        <= '0;
               busy     <= 1'b1;
               pass     <= 1'b0;
               fail_idx <= '0;
`ifdef RC4_FULL_SCAN_EN
               bad      <= 1'b0;
`endif
               if (msg_len == '0) begin
                  pass  <= 1'b1;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  state <= S_FETCH_I;
               end
            end
            S_FETCH_I: begin
               i     <= i + 1'b1;
               state <= S_FETCH_J;
            end
            S_FETCH_J: begin
               si    <= s_rdata;
               j     <= j_new;
               state <= S_SWAP_I;
            end
            S_SWAP_I: begin
               sj    <= s_rdata;
               state <= S_SWAP_J;
            end
            S_SWAP_J:  state <= S_FETCH_K;
            S_FETCH_K: state <= S_EMIT;
            S_EMIT: begin
`ifdef RC4_FULL_SCAN_EN
               if (!byte_ok && !bad) begin
                  fail_idx <= k;
                  bad      <= 1'b1;
               end
               if (last) begin
                  pass  <= byte_ok && !bad;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  k     <= k + 1'b1;
                  state <= S_FETCH_I;
               end
`else
               if (!byte_ok) begin
                  fail_idx <= k;
                  pass     <= 1'b0;
                  done     <= 1'b1;
                  state    <= S_DONE;
               end else if (last) begin
                  pass  <= 1'b1;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  k     <= k + 1'b1;
                  state <= S_FETCH_I;
               end
`endif
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/rc4_prga_checker.md
Name: rc4_prga_checker

Overview:
- Parametrised RC4 keystream generator (PRGA) and plaintext screener for the key-search datapath.
- Runs after an externally completed KSA has filled the S-box RAM. Decrypts a runtime-selected number of ciphertext bytes, writes plaintext to the answer RAM and reports pass/fail.
- Successor to the fixed-length decryptor. Adds runtime message length, a configurable accepted character range, a done/pass/fail-index handshake, and per-run i/j/k clearing.

Parameters:
- SBOX_AW, 8, S-box address width; S-box has 2^SBOX_AW entries, data width is fixed at 8.
- MSG_AW, 5, message address width; maximum message length is 2^MSG_AW.
- CHAR_LO, 97, lowest accepted plaintext byte value.
- CHAR_HI, 122, highest accepted plaintext byte value.
- CHAR_EXTRA, 32, one additional accepted byte value.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  level request; the rising edge launches a run
- msg_len  in  MSG_AW+1  number of bytes to process; sampled on launch
- busy  out  1  high from launch until done
- done  out  1  one-cycle pulse at end of run
- pass  out  1  valid while done is high; 1 = every byte was accepted
- fail_idx  out  MSG_AW  index of the first rejected byte; held until next launch
- s_addr  out  SBOX_AW  S-box address
- s_wdata  out  8  S-box write data
- s_wren  out  1  S-box write enable
- s_rdata  in  8  S-box read data; valid the cycle after the address is presented
- ct_addr  out  MSG_AW  ciphertext ROM address
- ct_rdata  in  8  ciphertext data; 1-cycle read latency
- pt_addr  out  MSG_AW  plaintext RAM address
- pt_wdata  out  8  plaintext byte
- pt_wren  out  1  plaintext write enable

Behaviour:
- Reset:
  - State returns to IDLE.
  - i, j, k, si, sj, fail_idx, busy, done, pass, all write enables and all addresses are 0.
  - Reset during a run aborts it with no done pulse. The write enables are low from the cycle after the reset edge.
- Launch:
  - In IDLE, a detected rising edge of start latches msg_len, clamped to 2^MSG_AW.
  - Launch clears i, j, k to 0 and sets busy.
  - start edges while busy are ignored.
  - msg_len == 0: go straight to DONE (pass = 1, no writes).
- State machine: IDLE -> FETCH_I -> FETCH_J -> SWAP_I -> SWAP_J -> FETCH_K -> EMIT -> (FETCH_I | DONE) -> IDLE.
  - FETCH_I: i <= i+1; s_addr = i+1 (mod 2^SBOX_AW).
  - FETCH_J: si <= s_rdata; j <= j + s_rdata (mod 2^SBOX_AW); s_addr = that new j.
  - SWAP_I: sj <= s_rdata; write s[i] = sj, i.e. the value of s_rdata.
  - SWAP_J: write s[j] = si.
  - FETCH_K: s_addr = si+sj (mod 2^SBOX_AW); ct_addr = k.
  - EMIT:
    - pt_wdata = s_rdata ^ ct_rdata; pt_addr = k; pt_wren = 1.
    - Byte is accepted iff CHAR_LO <= byte <= CHAR_HI or byte == CHAR_EXTRA.
    - Rejected: fail_idx <= k, pass <= 0, go to DONE.
    - Accepted and k == len-1: pass <= 1, go to DONE.
    - Otherwise k <= k+1, go to FETCH_I.
  - DONE: done = 1, busy = 0 next cycle, go to IDLE.
- Latency and write rules:
  - A full run takes 6*msg_len + 1 cycles, counted from the first FETCH_I through DONE inclusive.
  - s_wren is high only in SWAP_I and SWAP_J.
  - pt_wren is high only in EMIT.
  - Unused write data is 0.
- The rejected byte is still written to pt RAM.
- i == j: both swap writes hit the same address; the final value is si (a correct no-op swap).

Optional Feature:
- Macro RC4_FULL_SCAN_EN.
- Defined: a rejection does not abort. The run always processes msg_len bytes; fail_idx records the first rejected index; pass = 1 only if no byte was rejected; latency is always 6*msg_len + 1.
- Undefined: abort on the first rejection as described in Behaviour.

Decomposition:
- Package rc4_pkg holds:
  - the state enum;
  - default CHAR_LO, CHAR_HI and CHAR_EXTRA constants;
  - function char_ok(byte, lo, hi, extra).
- Sub-module: reuse the existing edge_detector for start.
- The rest stays flat, one FSM with its datapath registers.

Test Plan:
- Identity S-box (s[n] = n), ct = 8'h00 x4, msg_len = 4. Keystream from the model is ks = {s[1+1]=... } by construction, so the bench checks pt_wdata = model keystream. Required: pass = 1 only if all model bytes fall in 97..122 or equal 32; otherwise the matching fail_idx.
- Model-KSA S-box for key "Key", ct = BB F3 16 E8 D9 40 AF 0A D3, msg_len = 9 -> pt[0] = 8'h50 ('P') is rejected; done with pass = 0, fail_idx = 0, exactly one pt write, total cycles = 7.
- Same key, ct = model encryption of "hello world" (11 bytes) -> pass = 1, pt RAM equals "hello world", cycles = 67, final S-box matches the model.
- msg_len = 0 -> done pulse the cycle after launch, pass = 1, no s_wren or pt_wren activity.
- Reset asserted in SWAP_J of byte 2 -> idle next cycle, busy = 0, no done; a relaunch starts again from i = j = k = 0.
- With RC4_FULL_SCAN_EN defined, the "Key" vector with msg_len = 9 -> all 9 bytes written, fail_idx = 0, pass = 0, cycles = 55.
